// File: rtl/fft_seq_pkg.sv
// Shared types and defaults for the FFT input-frame sequencer.
package fft_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_N_POINTS = 64;
  localparam int DEFAULT_TRIG_IDX = 54;
  localparam int DEFAULT_FRAME_W  = 8;

  // Index width for a counter that must reach n-1; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULO up counter with enable, synchronous clear and a wrap pulse.
// wrap_o is combinational: it flags that the current enabled step rolls over.
module mod_counter
  import fft_seq_pkg::*;
#(
  parameter int MODULO = DEFAULT_N_POINTS,
  parameter int W      = idxWidth(MODULO)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && !clr_i && (cnt_q == W'(MODULO - 1));
  assign cnt_o  = cnt_q;

  // Clear dominates enable; an enabled step at the top value returns to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Input-frame sequencer: counts accepted samples per frame and emits a
// registered sample index with trigger and last-sample markers.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N_POINTS = DEFAULT_N_POINTS,
  parameter int ADDR_W   = idxWidth(N_POINTS),
  parameter int TRIG_IDX = DEFAULT_TRIG_IDX,
  parameter int FRAME_W  = DEFAULT_FRAME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic               continuous,
  input  logic               abort,
  input  logic               clr_err,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               addr_valid_o,
  output logic               trig_o,
  output logic               last_o,
  output logic               busy_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic               overrun_o
);

  if (N_POINTS < 4 || (N_POINTS & (N_POINTS - 1)) != 0) begin : gBadNPoints
    $error("fft_frame_sequencer: N_POINTS must be a power of two and at least 4");
  end
  if (TRIG_IDX < 0 || TRIG_IDX > N_POINTS - 1) begin : gBadTrigIdx
    $error("fft_frame_sequencer: TRIG_IDX must lie in 0..N_POINTS-1");
  end

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic               trig_q, trig_d;
  logic               last_q, last_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               overrun_q, overrun_d;

  logic [ADDR_W-1:0]  cnt;
  logic               accept;
  logic               finalAccept;
  logic               cntClr;
  logic               overrunSet;

  // A sample is taken only while running and not being aborted.
  assign accept     = (state_q == RUN) && in_valid && !abort;
  assign cntClr     = (state_q == IDLE) || abort;
  // A start that lands on the closing sample of a single-shot frame is a
  // legitimate follow-on request, not an overrun.
  assign overrunSet = (state_q == RUN) && start && !(finalAccept && !continuous);

  mod_counter #(
    .MODULO (N_POINTS),
    .W      (ADDR_W)
  ) uCnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (accept),
    .clr_i  (cntClr),
    .cnt_o  (cnt),
    .wrap_o (finalAccept)
  );

  // Next-state logic: abort wins, otherwise leave RUN only at a single-shot frame end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (finalAccept && !continuous) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output datapath: everything is one cycle behind the accepting edge.
  always_comb begin
    addr_d    = addr_q;
    valid_d   = accept;
    trig_d    = accept && (cnt == ADDR_W'(TRIG_IDX));
    last_d    = finalAccept;
    frame_d   = frame_q;
    overrun_d = overrun_q;
    if (accept) begin
      addr_d = cnt;
    end
    if (finalAccept) begin
      frame_d = frame_q + FRAME_W'(1);
    end
    if (overrunSet) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      trig_q    <= 1'b0;
      last_q    <= 1'b0;
      frame_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      trig_q    <= trig_d;
      last_q    <= last_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = valid_q;
  assign trig_o       = trig_q;
  assign last_o       = last_q;
  assign busy_o       = (state_q == RUN);
  assign frame_cnt_o  = frame_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: a default 64-point instance and a 16-point
// instance with the trigger on the last index, driven by the same stimulus.
module tb_fft_frame_sequencer;

  logic clk = 1'b0;
  logic rst, start, in_valid, continuous, abort, clr_err;

  logic [5:0] addr64;
  logic       av64, trig64, last64, busy64, ov64;
  logic [7:0] fc64;
  logic [3:0] addr16;
  logic       av16, trig16, last16, busy16, ov16;
  logic [7:0] fc16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer #(.N_POINTS(64), .TRIG_IDX(54), .FRAME_W(8)) dut64 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .continuous(continuous), .abort(abort), .clr_err(clr_err),
    .addr_o(addr64), .addr_valid_o(av64), .trig_o(trig64), .last_o(last64),
    .busy_o(busy64), .frame_cnt_o(fc64), .overrun_o(ov64)
  );

  fft_frame_sequencer #(.N_POINTS(16), .TRIG_IDX(15), .FRAME_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .continuous(continuous), .abort(abort), .clr_err(clr_err),
    .addr_o(addr16), .addr_valid_o(av16), .trig_o(trig16), .last_o(last16),
    .busy_o(busy16), .frame_cnt_o(fc16), .overrun_o(ov16)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic c,
                               input logic a, input logic ce);
    start = s; in_valid = v; continuous = c; abort = a; clr_err = ce;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model: per-instance frame progress described as "which sample
  // index comes next, is a frame open, how many frames have closed".
  int  nPts[2]    = '{64, 16};
  int  trigIdx[2] = '{54, 15};
  bit  mBusy[2];
  int  mIdx[2];
  int  mFrames[2];
  bit  mOver[2];
  int  mAddr[2];
  bit  mValid[2], mTrig[2], mLast[2];
  bit  modelReady = 1'b0;

  always @(posedge clk) begin
    bit taken, closing;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mBusy[i] = 0; mIdx[i] = 0; mFrames[i] = 0; mOver[i] = 0;
        mAddr[i] = 0; mValid[i] = 0; mTrig[i] = 0; mLast[i] = 0;
      end else begin
        taken   = mBusy[i] && in_valid && !abort;
        closing = taken && (mIdx[i] == nPts[i] - 1);
        mValid[i] = taken;
        mTrig[i]  = taken && (mIdx[i] == trigIdx[i]);
        mLast[i]  = closing;
        if (taken) mAddr[i] = mIdx[i];
        if (mBusy[i] && start && !(closing && !continuous)) mOver[i] = 1;
        else if (clr_err) mOver[i] = 0;
        if (!mBusy[i]) begin
          if (start) begin mBusy[i] = 1; mIdx[i] = 0; end
        end else if (abort) begin
          mBusy[i] = 0; mIdx[i] = 0;
        end else if (taken) begin
          if (closing) begin
            mFrames[i]++;
            mIdx[i] = 0;
            if (!continuous) mBusy[i] = 0;
          end else begin
            mIdx[i]++;
          end
        end
      end
    end
    if (rst) modelReady = 1'b1;
  end

  // Per-cycle comparison against the model plus bookkeeping for frame-level checks.
  int validCount64 = 0, trigCount64 = 0, lastCount64 = 0, trigAddr64 = -1;
  int runLen64 = 0, maxRun64 = 0, bothCount16 = 0, xorCount16 = 0;

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("addr64",  32'(addr64), 32'(mAddr[0]));
      checkOutput("valid64", 32'(av64),   32'(mValid[0]));
      checkOutput("trig64",  32'(trig64), 32'(mTrig[0]));
      checkOutput("last64",  32'(last64), 32'(mLast[0]));
      checkOutput("busy64",  32'(busy64), 32'(mBusy[0]));
      checkOutput("frames64", 32'(fc64),  32'(mFrames[0] % 256));
      checkOutput("overrun64", 32'(ov64), 32'(mOver[0]));
      checkOutput("addr16",  32'(addr16), 32'(mAddr[1]));
      checkOutput("valid16", 32'(av16),   32'(mValid[1]));
      checkOutput("trig16",  32'(trig16), 32'(mTrig[1]));
      checkOutput("last16",  32'(last16), 32'(mLast[1]));
      checkOutput("busy16",  32'(busy16), 32'(mBusy[1]));
      checkOutput("frames16", 32'(fc16),  32'(mFrames[1] % 256));
      checkOutput("overrun16", 32'(ov16), 32'(mOver[1]));
      if (av64 === 1'b1) begin validCount64++; runLen64++; end
      else runLen64 = 0;
      if (runLen64 > maxRun64) maxRun64 = runLen64;
      if (trig64 === 1'b1) begin trigCount64++; trigAddr64 = int'(addr64); end
      if (last64 === 1'b1) lastCount64++;
      if (trig16 === 1'b1 && last16 === 1'b1) bothCount16++;
      if (trig16 !== last16) xorCount16++;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0, t0, l0, k;
    rst = 1'b1; start = 0; in_valid = 0; continuous = 0; abort = 0; clr_err = 0;
    idle(2);
    checkOutput("resetBusy", 32'(busy64), 0);
    checkOutput("resetFrames", 32'(fc64), 0);
    checkOutput("resetValid", 32'(av64), 0);
    rst = 1'b0;
    idle(1);

    $display("[TB] single-shot frame, unstalled");
    v0 = validCount64; t0 = trigCount64;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("busyAfterStart", 32'(busy64), 1);
    repeat (64) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("lastAtEnd", 32'(last64), 1);
    checkOutput("addrAtEnd", 32'(addr64), 63);
    checkOutput("busyFallsWithLast", 32'(busy64), 0);
    checkOutput("framesAfterOne", 32'(fc64), 1);
    idle(2);
    checkOutput("validCountFrame1", 32'(validCount64 - v0), 64);
    checkOutput("trigCountFrame1", 32'(trigCount64 - t0), 1);
    checkOutput("trigAddrFrame1", 32'(trigAddr64), 54);

    $display("[TB] single-shot frame, random stalls");
    v0 = validCount64; t0 = trigCount64; trigAddr64 = -1;
    applyStimulus(1, 0, 0, 0, 0);
    k = 0;
    while (mBusy[0] && k < 400) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 0, 0, 0);
      k++;
    end
    checkOutput("randomFrameDone", 32'(k < 400), 1);
    idle(2);
    checkOutput("validCountRandom", 32'(validCount64 - v0), 64);
    checkOutput("trigCountRandom", 32'(trigCount64 - t0), 1);
    checkOutput("trigAddrRandom", 32'(trigAddr64), 54);
    checkOutput("framesAfterTwo", 32'(fc64), 2);

    $display("[TB] three back-to-back frames");
    v0 = validCount64; maxRun64 = 0;
    applyStimulus(1, 0, 1, 0, 0);
    for (int j = 0; j < 192; j++) applyStimulus(0, 1, 1'(j < 191), 0, 0);
    checkOutput("busyAfterChain", 32'(busy64), 0);
    checkOutput("framesAfterChain", 32'(fc64), 5);
    idle(2);
    checkOutput("validCountChain", 32'(validCount64 - v0), 192);
    checkOutput("unbrokenRun", 32'(maxRun64), 192);

    $display("[TB] abort mid-frame");
    t0 = trigCount64; l0 = lastCount64;
    applyStimulus(1, 0, 0, 0, 0);
    repeat (20) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("busyAfterAbort", 32'(busy64), 0);
    checkOutput("validOnAbort", 32'(av64), 0);
    idle(2);
    checkOutput("framesAfterAbort", 32'(fc64), 5);
    checkOutput("trigAfterAbort", 32'(trigCount64 - t0), 0);
    checkOutput("lastAfterAbort", 32'(lastCount64 - l0), 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("restartIndex", 32'(addr64), 0);
    repeat (63) applyStimulus(0, 1, 0, 0, 0);
    idle(2);
    checkOutput("framesAfterRestart", 32'(fc64), 6);

    $display("[TB] overrun and clear");
    applyStimulus(1, 0, 0, 0, 0);
    for (int j = 0; j < 64; j++) begin
      applyStimulus(1'(j == 5 || j == 63), 1, 0, 0, 1'(j == 10));
      if (j == 5) checkOutput("overrunSet", 32'(ov64), 1);
      if (j == 9) checkOutput("overrunSticky", 32'(ov64), 1);
      if (j == 10) checkOutput("overrunCleared", 32'(ov64), 0);
    end
    checkOutput("noOverrunOnFinal", 32'(ov64), 0);
    checkOutput("idleAfterFinal", 32'(busy64), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restartAfterFinal", 32'(busy64), 1);
    repeat (64) applyStimulus(0, 1, 0, 0, 0);
    idle(2);
    checkOutput("framesAfterOverrun", 32'(fc64), 8);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 0, 0, 0, 0);
    repeat (8) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("addrBeforeReset", 32'(addr64), 7);
    rst = 1'b1;
    applyStimulus(0, 1, 0, 0, 0);
    rst = 1'b0;
    checkOutput("rstAddr64", 32'(addr64), 0);
    checkOutput("rstBusy64", 32'(busy64), 0);
    checkOutput("rstFrames64", 32'(fc64), 0);
    checkOutput("rstValid64", 32'(av64), 0);
    checkOutput("rstBusy16", 32'(busy16), 0);
    checkOutput("rstOverrun16", 32'(ov16), 0);

    $display("[TB] trigger on last index, 16-point instance");
    applyStimulus(1, 0, 0, 0, 0);
    repeat (16) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("trigWithLast16", 32'({trig16, last16}), 3);
    checkOutput("addrAtLast16", 32'(addr16), 15);
    checkOutput("frames16", 32'(fc16), 1);
    idle(2);
    checkOutput("trigLastApart16", 32'(xorCount16), 0);
    checkOutput("trigLastTogether16", 32'(bothCount16 > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
